vector_issue_ctrl: RTL

VECTOR_ISSUE_CTRL -- requirements
Module: vector_issue_ctrl

---
 rtl/vector_issue_ctrl_pkg.sv | 21 ++
 rtl/vector_inst_check.sv | 51 +++++
 rtl/vector_issue_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vector_issue_ctrl_pkg.sv
// Shared opcode constants, state encoding and register-group geometry for the vector issue controller.
package vector_issue_ctrl_pkg;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned GRP_SIZE = 4;

  localparam logic [OPC_W-1:0] OPC_VXOR     = 6'b001011;
  localparam logic [OPC_W-1:0] OPC_VRGATHER = 6'b001100;
  localparam logic [OPC_W-1:0] OPC_VSLIDEUP = 6'b001110;
  localparam logic [OPC_W-1:0] OPC_VREDSUM  = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_VMACC    = 6'b101101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/vector_inst_check.sv
// Combinational opcode decode and register-group legality check.
module vector_inst_check
  import vector_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [REG_AW-1:0] vs2,
  input  logic [REG_AW-1:0] vs1,
  input  logic [REG_AW-1:0] vd,
  input  logic              lmul,
  output logic              legal_c,
  output logic              is_vmacc_c,
  output logic              is_slide_c,
  output logic              is_red_c
);

  logic        is_xor;
  logic        is_gather;
  logic        known;
  logic        vd_al;
  logic        vs2_al;
  logic        vs1_al;
  logic        align_ok;
  logic        overlap;
  logic [31:0] grp;
  logic [31:0] vd_w;
  logic [31:0] vs2_w;

  assign is_xor     = (opcode == OPC_VXOR);
  assign is_gather  = (opcode == OPC_VRGATHER);
  assign is_slide_c = (opcode == OPC_VSLIDEUP);
  assign is_red_c   = (opcode == OPC_VREDSUM);
  assign is_vmacc_c = (opcode == OPC_VMACC);
  assign known      = is_xor | is_gather | is_slide_c | is_red_c | is_vmacc_c;

  // Group bases must sit on a group boundary when a four-register group is used.
  assign vd_al    = ((32'(vd)  % GRP_SIZE) == 32'd0);
  assign vs2_al   = ((32'(vs2) % GRP_SIZE) == 32'd0);
  assign vs1_al   = ((32'(vs1) % GRP_SIZE) == 32'd0);
  assign align_ok = !lmul || (vd_al && vs2_al && (is_slide_c || vs1_al));

  // Slide-up destination may not overlap its source group.
  assign grp     = lmul ? GRP_SIZE : 32'd1;
  assign vd_w    = 32'(vd);
  assign vs2_w   = 32'(vs2);
  assign overlap = (vd_w < vs2_w + grp) && (vs2_w < vd_w + grp);

  assign legal_c = known && align_ok && !(is_slide_c && overlap);

endmodule

// File: rtl/vector_issue_ctrl.sv
// Vector instruction issue controller: sequences RF reads, capture and write-back per instruction.
module vector_issue_ctrl
  import vector_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NPORT  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vsi_valid,
  output logic                    vsi_ready,
  input  logic [31:0]             vsi_op,
  input  logic                    vsi_sew,
  input  logic                    vsi_lmul,
  output logic [31:0]             op_q,
  output logic                    sew_q,
  output logic                    lmul_q,
  output logic [NPORT-1:0]        rf_re,
  output logic [NPORT*REG_AW-1:0] rf_raddr,
  output logic                    vs_cap_en,
  output logic [3:0]              rf_we,
  output logic [REG_AW-1:0]       rf_waddr,
  output logic                    vsi_done,
  output logic                    vsi_err
);

  localparam int unsigned RAW = NPORT * REG_AW;

  state_e                state_q, state_d;
  logic [31:0]           op_r_q, op_d;
  logic                  sew_r_q, sew_d;
  logic                  lmul_r_q, lmul_d;
  logic                  is_vmacc_q, is_vmacc_d;
  logic                  is_red_q, is_red_d;
  logic                  ready_q, ready_d;
  logic [NPORT-1:0]      rf_re_q, rf_re_d;
  logic [RAW-1:0]        rf_raddr_q, rf_raddr_d;
  logic                  cap_q, cap_d;
  logic [3:0]            rf_we_q, rf_we_d;
  logic [REG_AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  chk_legal;
  logic                  chk_vmacc;
  logic                  chk_slide;
  logic                  chk_red;
  logic [REG_AW-1:0]     in_vs2;
  logic [REG_AW-1:0]     in_vs1;
  logic [REG_AW-1:0]     in_vd;
  logic [REG_AW-1:0]     q_vd;

  assign in_vs2 = REG_AW'(vsi_op[24:20]);
  assign in_vs1 = REG_AW'(vsi_op[19:15]);
  assign in_vd  = REG_AW'(vsi_op[11:7]);
  assign q_vd   = REG_AW'(op_r_q[11:7]);

  // Decode the offered instruction so the first read can issue right after accept.
  vector_inst_check #(.REG_AW(REG_AW)) u_check (
    .opcode     (vsi_op[31:26]),
    .vs2        (in_vs2),
    .vs1        (in_vs1),
    .vd         (in_vd),
    .lmul       (vsi_lmul),
    .legal_c    (chk_legal),
    .is_vmacc_c (chk_vmacc),
    .is_slide_c (chk_slide),
    .is_red_c   (chk_red)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    op_d       = op_r_q;
    sew_d      = sew_r_q;
    lmul_d     = lmul_r_q;
    is_vmacc_d = is_vmacc_q;
    is_red_d   = is_red_q;
    rf_re_d    = '0;
    rf_raddr_d = '0;
    cap_d      = 1'b0;
    rf_we_d    = 4'b0000;
    rf_waddr_d = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vsi_valid) begin
          op_d       = vsi_op;
          sew_d      = vsi_sew;
          lmul_d     = vsi_lmul;
          is_vmacc_d = chk_vmacc;
          is_red_d   = chk_red;
          if (chk_legal) begin
            state_d = ST_RD1;
            for (int unsigned i = 0; i < GRP_SIZE; i++) begin
              if (vsi_lmul || i == 0) begin
                rf_re_d[i]                        = 1'b1;
                rf_raddr_d[i*REG_AW +: REG_AW]    = in_vs2 + REG_AW'(i);
              end
            end
            for (int unsigned i = 0; i < GRP_SIZE; i++) begin
              if (chk_slide) begin
                if (vsi_lmul) begin
                  rf_re_d[GRP_SIZE+i]                       = 1'b1;
                  rf_raddr_d[(GRP_SIZE+i)*REG_AW +: REG_AW] = in_vd + REG_AW'(i);
                end else if (i == GRP_SIZE - 1) begin
                  rf_re_d[GRP_SIZE+i]                       = 1'b1;
                  rf_raddr_d[(GRP_SIZE+i)*REG_AW +: REG_AW] = in_vd;
                end
              end else if (vsi_lmul || i == 0) begin
                rf_re_d[GRP_SIZE+i]                       = 1'b1;
                rf_raddr_d[(GRP_SIZE+i)*REG_AW +: REG_AW] = in_vs1 + REG_AW'(i);
              end
            end
          end else begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_RD1: begin
        if (is_vmacc_q) begin
          state_d = ST_RD2;
          cap_d   = 1'b1;
          for (int unsigned i = 0; i < GRP_SIZE; i++) begin
            if (lmul_r_q) begin
              rf_re_d[GRP_SIZE+i]                       = 1'b1;
              rf_raddr_d[(GRP_SIZE+i)*REG_AW +: REG_AW] = q_vd + REG_AW'(i);
            end else if (i == GRP_SIZE - 1) begin
              rf_re_d[GRP_SIZE+i]                       = 1'b1;
              rf_raddr_d[(GRP_SIZE+i)*REG_AW +: REG_AW] = q_vd;
            end
          end
        end else begin
          state_d    = ST_WB;
          rf_we_d    = (lmul_r_q && !is_red_q) ? 4'b1111 : 4'b0001;
          rf_waddr_d = q_vd;
          done_d     = 1'b1;
        end
      end
      ST_RD2: begin
        state_d    = ST_WB;
        rf_we_d    = (lmul_r_q && !is_red_q) ? 4'b1111 : 4'b0001;
        rf_waddr_d = q_vd;
        done_d     = 1'b1;
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_r_q     <= '0;
      sew_r_q    <= 1'b0;
      lmul_r_q   <= 1'b0;
      is_vmacc_q <= 1'b0;
      is_red_q   <= 1'b0;
      ready_q    <= 1'b1;
      rf_re_q    <= '0;
      rf_raddr_q <= '0;
      cap_q      <= 1'b0;
      rf_we_q    <= 4'b0000;
      rf_waddr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_r_q     <= op_d;
      sew_r_q    <= sew_d;
      lmul_r_q   <= lmul_d;
      is_vmacc_q <= is_vmacc_d;
      is_red_q   <= is_red_d;
      ready_q    <= ready_d;
      rf_re_q    <= rf_re_d;
      rf_raddr_q <= rf_raddr_d;
      cap_q      <= cap_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign vsi_ready = ready_q;
  assign op_q      = op_r_q;
  assign sew_q     = sew_r_q;
  assign lmul_q    = lmul_r_q;
  assign rf_re     = rf_re_q;
  assign rf_raddr  = rf_raddr_q;
  assign vs_cap_en = cap_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign vsi_done  = done_q;
  assign vsi_err   = err_q;

endmodule
